// File: rtl/bf8b_pkg.sv
// Shared types for the 8-bit fetch path: bus widths, instruction classes and queue entry layout.
package bf8b_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        INST_JMP   = 2'b00,
        INST_ALU   = 2'b01,
        INST_LOAD  = 2'b10,
        INST_STORE = 2'b11
    } inst_type_t;

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// DEPTH-entry ring of fetch entries with occupancy count, push/pop and single-cycle flush.
module sync_fifo
    import bf8b_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    fetch_entry_t     mem [DEPTH];

    logic do_push;
    logic do_pop;

    // A full ring only accepts a push when the head leaves in the same cycle.
    assign do_push = push && !flush && ((count_reg != CNT_W'(DEPTH)) || pop);
    assign do_pop  = pop && !flush && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= wr_ptr_reg;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_ptr_reg] <= push_data;
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch: issues sequential fetches against a credit limit, buffers responses, handles redirects.
// Optional PREFETCH_BYPASS_EN presents a response straight to decode when the queue is empty.
module prefetch_queue
    import bf8b_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fpc_reg;
    logic [ADDR_W-1:0] tag_reg;
    logic              inflight_reg;

    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    fetch_entry_t      head;
    fetch_entry_t      push_data;
    logic              accept;
    logic              resp;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    // Credits come from registered state only, so a pop frees a slot one cycle later.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
    assign mem_req     = rst_n && !redirect && (credit_used < (CNT_W+1)'(DEPTH));
    assign mem_addr    = fpc_reg;
    assign accept      = mem_req && mem_gnt;

    assign resp        = rst_n && inflight_reg && !redirect;
    assign fifo_empty  = (fifo_count == '0);
    assign push_data   = '{inst: mem_data, pc: tag_reg};

`ifdef PREFETCH_BYPASS_EN
    logic bypass;

    assign bypass     = fifo_empty && resp;
    assign inst_valid = rst_n && !redirect && (!fifo_empty || bypass);
    assign inst       = bypass ? mem_data : head.inst;
    assign inst_pc    = bypass ? tag_reg  : head.pc;
    assign fifo_push  = resp && !(bypass && inst_ready);
`else
    assign inst_valid = rst_n && !redirect && !fifo_empty;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign fifo_push  = resp;
`endif

    assign fifo_pop = inst_valid && inst_ready && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc_reg      <= RESET_PC;
            tag_reg      <= RESET_PC;
            inflight_reg <= 1'b0;
        end else if (redirect) begin
            fpc_reg      <= redirect_pc;
            inflight_reg <= 1'b0;
        end else if (accept) begin
            fpc_reg      <= fpc_reg + ADDR_W'(1);
            tag_reg      <= fpc_reg;
            inflight_reg <= 1'b1;
        end else begin
            inflight_reg <= 1'b0;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: fill, streaming, wrap, redirect flush, bus stalls and mid-stream reset.
module tb_prefetch_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_gnt = 1'b0;
    logic [7:0] mem_data = 8'h00;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       inst_valid;
    logic [7:0] inst;
    logic [7:0] inst_pc;
    logic       inst_ready = 1'b0;

    always #5 clk = ~clk;

    prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_data    (mem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    int         tests = 0;
    int         fails = 0;
    logic       s_req;
    logic       s_valid;
    logic [7:0] s_addr;
    logic [7:0] s_inst;
    logic [7:0] s_pc;
    logic       rsp_valid = 1'b0;
    logic [7:0] rsp_addr = 8'h00;
    logic [7:0] exp_pc = 8'h00;
    logic [7:0] exp_fa = 8'h00;
    int         acc_cnt = 0;
    int         pop_cnt = 0;
    bit         stream_chk = 1'b0;
    bit         fa_chk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: sample outputs mid-cycle, model acceptance and pops, then answer one cycle after acceptance.
    task automatic cyc();
        logic       acc;
        logic [7:0] a;
        #2;
        s_req   = mem_req;
        s_addr  = mem_addr;
        s_valid = inst_valid;
        s_inst  = inst;
        s_pc    = inst_pc;
        acc     = (mem_req === 1'b1) && mem_gnt;
        a       = mem_addr;
        if (acc) begin
            acc_cnt++;
            if (fa_chk) begin
                chk("fetch_addr", 32'(a), 32'(exp_fa));
                exp_fa = exp_fa + 8'd1;
            end
        end
        if ((inst_valid === 1'b1) && inst_ready) begin
            pop_cnt++;
            if (stream_chk) begin
                chk("pop_pc", 32'(inst_pc), 32'(exp_pc));
                chk("pop_inst", 32'(inst), 32'(exp_pc ^ 8'hA5));
                exp_pc = exp_pc + 8'd1;
            end
        end
        @(posedge clk);
        #1;
        rsp_valid = acc;
        rsp_addr  = a;
        mem_data  = acc ? (a ^ 8'hA5) : 8'h00;
    endtask

    initial begin
        logic [31:0] gpat;
        logic [31:0] rpat;
        logic        prev_stall;
        logic [7:0]  prev_addr;

        // 1: reset, then fill with decode stalled
        rst_n = 1'b0; mem_gnt = 1'b1; inst_ready = 1'b0;
        cyc();
        chk("rst_req", 32'(s_req), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        cyc();
        rst_n = 1'b1; fa_chk = 1'b1; exp_fa = 8'h00; acc_cnt = 0;
        cyc();
        chk("t1_req0", 32'(s_req), 32'd1);
        chk("t1_addr0", 32'(s_addr), 32'h00);
        chk("t1_valid_c0", 32'(s_valid), 32'd0);
        cyc();
        chk("t1_valid_c1", 32'(s_valid), 32'd0);
        cyc();
        chk("t1_valid_c2", 32'(s_valid), 32'd1);
        chk("t1_head_pc", 32'(s_pc), 32'h00);
        chk("t1_head_inst", 32'(s_inst), 32'hA5);
        repeat (4) cyc();
        chk("t1_accepts", 32'(acc_cnt), 32'd4);
        chk("t1_req_full", 32'(s_req), 32'd0);
        chk("t1_count", 32'(dut.fifo_count), 32'd4);

        // 2: streaming, one instruction per cycle once the pipe is primed
        inst_ready = 1'b1; stream_chk = 1'b1; exp_pc = 8'h00; pop_cnt = 0;
        repeat (20) cyc();
        chk("t2_pops", 32'(pop_cnt), 32'd20);
        inst_ready = 1'b0;
        repeat (3) cyc();

        // 3: redirect to FE and run across the address wrap
        redirect = 1'b1; redirect_pc = 8'hFE; inst_ready = 1'b1;
        cyc();
        chk("t3_redir_valid", 32'(s_valid), 32'd0);
        chk("t3_redir_req", 32'(s_req), 32'd0);
        redirect = 1'b0; exp_pc = 8'hFE; exp_fa = 8'hFE; pop_cnt = 0;
        cyc();
        chk("t3_addr", 32'(s_addr), 32'hFE);
        chk("t3_valid_r1", 32'(s_valid), 32'd0);
        cyc();
        chk("t3_valid_r2", 32'(s_valid), 32'd0);
        repeat (6) cyc();
        chk("t3_pops", 32'(pop_cnt), 32'd6);

        // 4: redirect to 40 exactly when the response for 05 arrives
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid && (rsp_addr == 8'h05)) break;
            cyc();
        end
        chk("t4_resp05", 32'(rsp_addr), 32'h05);
        redirect = 1'b1; redirect_pc = 8'h40;
        cyc();
        chk("t4_redir_valid", 32'(s_valid), 32'd0);
        chk("t4_flushed", 32'(dut.fifo_count), 32'd0);
        redirect = 1'b0; exp_pc = 8'h40; exp_fa = 8'h40; pop_cnt = 0;
        cyc();
        chk("t4_addr", 32'(s_addr), 32'h40);
        chk("t4_empty", 32'(s_valid), 32'd0);
        repeat (5) cyc();
        chk("t4_pops", 32'(pop_cnt), 32'd4);

        // 5: grant and ready in irregular patterns
        gpat = 32'b1011_0010_0111_0001_1100_1010_0110_1001;
        rpat = 32'b1101_1011_0110_1110_0111_1011_1010_1101;
        prev_stall = 1'b0; prev_addr = 8'h00;
        for (int i = 0; i < 32; i++) begin
            mem_gnt = gpat[i]; inst_ready = rpat[i];
            cyc();
            if (prev_stall) begin
                chk("t5_stall_req", 32'(s_req), 32'd1);
                chk("t5_stall_addr", 32'(s_addr), 32'(prev_addr));
            end
            prev_stall = s_req && !mem_gnt;
            prev_addr  = s_addr;
        end
        mem_gnt = 1'b0; inst_ready = 1'b1;
        repeat (8) cyc();
        chk("t5_all_delivered", 32'(exp_pc), 32'(exp_fa));
        chk("t5_drained", 32'(s_valid), 32'd0);

        // 6: one-cycle reset while a response is in flight
        mem_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) break;
            cyc();
        end
        chk("t6_inflight", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        cyc();
        chk("t6_rst_valid", 32'(s_valid), 32'd0);
        chk("t6_rst_req", 32'(s_req), 32'd0);
        rst_n = 1'b1; exp_pc = 8'h00; exp_fa = 8'h00; pop_cnt = 0;
        cyc();
        chk("t6_req", 32'(s_req), 32'd1);
        chk("t6_addr", 32'(s_addr), 32'h00);
        chk("t6_valid_c0", 32'(s_valid), 32'd0);
        cyc();
        chk("t6_valid_c1", 32'(s_valid), 32'd0);
        repeat (6) cyc();
        chk("t6_pops", 32'(pop_cnt), 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
